// File: rtl/dp_mem_ctrl.sv
// Dual-port byte-addressed 32-bit simulation memory: port 0 read/write data port,
// port 1 read-only instruction port, fixed read latency, clear-on-reset fill sequencer.
module dp_mem_ctrl #(
  parameter int         DEPTH_BYTES = 1024,
  parameter int         RD_LATENCY  = 1,
  parameter bit         BIG_ENDIAN  = 1'b1,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_done,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_we,
  input  logic [3:0]  p0_wmask,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_addr,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam int          IW        = AW - 2;
  localparam int          WORDS     = DEPTH_BYTES / 4;
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_BYTES - 4);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   clr_cnt;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            p0_acc, p1_acc, p0_err, p1_err, p0_wr;
  logic [IW-1:0]   p0_idx, p1_idx;
  logic [31:0]     p0_word, p1_word;

  // Data lane (wmask bit / data byte) that holds the byte at addr+k.
  function automatic logic [1:0] lane(input logic [1:0] k);
    return BIG_ENDIAN ? ~k : k;
  endfunction

  // Handshake: a request is taken on any clk edge where valid && ready; ready is
  // high every RUN cycle, responses cannot be stalled, so there is no rsp ready.
  assign p0_acc = p0_req_valid && p0_req_ready;
  assign p1_acc = p1_req_valid && p1_req_ready;
  assign p0_err = (p0_addr[1:0] != 2'b00) || (p0_addr > LAST_ADDR);
  assign p1_err = (p1_addr[1:0] != 2'b00) || (p1_addr > LAST_ADDR);
  assign p0_idx = p0_addr[AW-1:2];
  assign p1_idx = p1_addr[AW-1:2];
  assign p0_wr  = p0_acc && p0_we && !p0_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (clr_cnt == IW'(WORDS - 1)) next_state = ST_RUN;
      ST_RUN:   next_state = ST_RUN;
      default:  next_state = ST_CLEAR;
    endcase
  end

  always_comb begin
    init_done    = (state == ST_RUN);
    p0_req_ready = (state == ST_RUN);
    p1_req_ready = (state == ST_RUN);
  end

  // Combinational array read; registering it at the acceptance edge gives read-before-write.
  always_comb begin
    p0_word = '0;
    p1_word = '0;
    for (int k = 0; k < 4; k++) begin
      p0_word[{lane(2'(k)), 3'b000} +: 8] = mem[{p0_idx, 2'(k)}];
      p1_word[{lane(2'(k)), 3'b000} +: 8] = mem[{p1_idx, 2'(k)}];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      for (int k = 0; k < 4; k++) mem[{clr_cnt, 2'(k)}] <= FILL_BYTE;
    end else if (p0_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (p0_wmask[lane(2'(k))])
          mem[{p0_idx, 2'(k)}] <= p0_wdata[{lane(2'(k)), 3'b000} +: 8];
      end
    end
  end

  logic [RD_LATENCY-1:0] p0_v_q, p0_e_q, p1_v_q, p1_e_q;
  logic [31:0]           p0_d_q [RD_LATENCY];
  logic [31:0]           p1_d_q [RD_LATENCY];

  // Response pipeline; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_v_q <= '0;
      p0_e_q <= '0;
      p1_v_q <= '0;
      p1_e_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        p0_d_q[i] <= '0;
        p1_d_q[i] <= '0;
      end
    end else begin
      p0_v_q[0] <= p0_acc;
      p0_e_q[0] <= p0_acc && p0_err;
      p0_d_q[0] <= (p0_acc && !p0_we && !p0_err) ? p0_word : '0;
      p1_v_q[0] <= p1_acc;
      p1_e_q[0] <= p1_acc && p1_err;
      p1_d_q[0] <= (p1_acc && !p1_err) ? p1_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        p0_v_q[i] <= p0_v_q[i-1];
        p0_e_q[i] <= p0_e_q[i-1];
        p0_d_q[i] <= p0_d_q[i-1];
        p1_v_q[i] <= p1_v_q[i-1];
        p1_e_q[i] <= p1_e_q[i-1];
        p1_d_q[i] <= p1_d_q[i-1];
      end
    end
  end

  assign p0_rsp_valid = p0_v_q[RD_LATENCY-1];
  assign p0_rsp_err   = p0_e_q[RD_LATENCY-1];
  assign p0_rsp_rdata = p0_d_q[RD_LATENCY-1];
  assign p1_rsp_valid = p1_v_q[RD_LATENCY-1];
  assign p1_rsp_err   = p1_e_q[RD_LATENCY-1];
  assign p1_rsp_rdata = p1_d_q[RD_LATENCY-1];

endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Bench for dp_mem_ctrl: three instances (64B/lat1/BE, 1K/lat2/LE, 1K/lat4/BE),
// vector table plus hand sequences, responses checked against an expected queue.
module tb_dp_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic        init_done    [3];
  logic        p0_req_valid [3];
  logic        p0_req_ready [3];
  logic        p0_we        [3];
  logic [3:0]  p0_wmask     [3];
  logic [31:0] p0_addr      [3];
  logic [31:0] p0_wdata     [3];
  logic        p0_rsp_valid [3];
  logic [31:0] p0_rsp_rdata [3];
  logic        p0_rsp_err   [3];
  logic        p1_req_valid [3];
  logic        p1_req_ready [3];
  logic [31:0] p1_addr      [3];
  logic        p1_rsp_valid [3];
  logic [31:0] p1_rsp_rdata [3];
  logic        p1_rsp_err   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dp_mem_ctrl #(
      .DEPTH_BYTES(g == 0 ? 64 : 1024),
      .RD_LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 4)),
      .BIG_ENDIAN (g == 1 ? 1'b0 : 1'b1),
      .FILL_BYTE  (g == 0 ? 8'hA5 : 8'h00)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .init_done   (init_done[g]),
      .p0_req_valid(p0_req_valid[g]),
      .p0_req_ready(p0_req_ready[g]),
      .p0_we       (p0_we[g]),
      .p0_wmask    (p0_wmask[g]),
      .p0_addr     (p0_addr[g]),
      .p0_wdata    (p0_wdata[g]),
      .p0_rsp_valid(p0_rsp_valid[g]),
      .p0_rsp_rdata(p0_rsp_rdata[g]),
      .p0_rsp_err  (p0_rsp_err[g]),
      .p1_req_valid(p1_req_valid[g]),
      .p1_req_ready(p1_req_ready[g]),
      .p1_addr     (p1_addr[g]),
      .p1_rsp_valid(p1_rsp_valid[g]),
      .p1_rsp_rdata(p1_rsp_rdata[g]),
      .p1_rsp_err  (p1_rsp_err[g])
    );
  end

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus records ----------------
  typedef struct {
    int          inst;
    logic        v0;
    logic        we;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    logic        e0;
    logic [31:0] r0;
    logic        v1;
    logic [31:0] a1;
    logic        e1;
    logic [31:0] r1;
  } vec_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [19:0] cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  vec_t tbl[$];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic vec_t idle(input int i);
    vec_t v;
    v = '{default: '0};
    v.inst = i;
    return v;
  endfunction

  function automatic vec_t rd0(input int i, input logic [31:0] a, input logic e, input logic [31:0] r);
    vec_t v = idle(i);
    v.v0 = 1'b1; v.a = a; v.e0 = e; v.r0 = r;
    return v;
  endfunction

  function automatic vec_t wr0(input int i, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m, input logic e);
    vec_t v = idle(i);
    v.v0 = 1'b1; v.we = 1'b1; v.m = m; v.a = a; v.d = d; v.e0 = e; v.r0 = '0;
    return v;
  endfunction

  function automatic vec_t rd1(input int i, input logic [31:0] a, input logic e, input logic [31:0] r);
    vec_t v = idle(i);
    v.v1 = 1'b1; v.a1 = a; v.e1 = e; v.r1 = r;
    return v;
  endfunction

  function automatic vec_t both(input vec_t x, input vec_t y);
    vec_t v = x;
    v.v1 = y.v1; v.a1 = y.a1; v.e1 = y.e1; v.r1 = y.r1;
    return v;
  endfunction

  function automatic logic [31:0] sweep_val(input int i, input int k);
    return 32'hA000_0000 + 32'(i * 256 + k);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input vec_t v);
    int   i = v.inst;
    exp_t e;
    p0_req_valid[i] = v.v0;
    p0_we[i]        = v.we;
    p0_wmask[i]     = v.m;
    p0_addr[i]      = v.a;
    p0_wdata[i]     = v.d;
    p1_req_valid[i] = v.v1;
    p1_addr[i]      = v.a1;
    if (v.v0) begin
      e.inst = 2'(i); e.cyc = 20'(cyc + lat_of(i)); e.err = v.e0; e.rdata = v.r0;
      exp_q0.push_back(e);
    end
    if (v.v1) begin
      e.inst = 2'(i); e.cyc = 20'(cyc + lat_of(i)); e.err = v.e1; e.rdata = v.r1;
      exp_q1.push_back(e);
    end
    @(posedge clk); #1;
    p0_req_valid[i] = 1'b0;
    p1_req_valid[i] = 1'b0;
    p0_we[i]        = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic wait_init(input int bound);
    int t = 0;
    while (!(init_done[0] && init_done[1] && init_done[2]) && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    check("init_all", 32'(init_done[0] && init_done[1] && init_done[2]), 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    int   hit;
    if (!rst) begin
      hit = -1;
      if (exp_q0.size() > 0 && exp_q0[0].cyc == cyc[19:0]) begin
        e = exp_q0.pop_front();
        hit = int'(e.inst);
        check("p0_rsp_valid", 32'(p0_rsp_valid[hit]), 32'd1);
        check("p0_rsp_err", 32'(p0_rsp_err[hit]), 32'(e.err));
        check("p0_rsp_rdata", p0_rsp_rdata[hit], e.rdata);
      end
      for (int i = 0; i < 3; i++) if (i != hit) check("p0_idle", 32'(p0_rsp_valid[i]), 32'd0);
      hit = -1;
      if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc[19:0]) begin
        e = exp_q1.pop_front();
        hit = int'(e.inst);
        check("p1_rsp_valid", 32'(p1_rsp_valid[hit]), 32'd1);
        check("p1_rsp_err", 32'(p1_rsp_err[hit]), 32'(e.err));
        check("p1_rsp_rdata", p1_rsp_rdata[hit], e.rdata);
      end
      for (int i = 0; i < 3; i++) if (i != hit) check("p1_idle", 32'(p1_rsp_valid[i]), 32'd0);
    end
  end

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      p0_req_valid[i] = 1'b0; p0_we[i] = 1'b0; p0_wmask[i] = '0;
      p0_addr[i] = '0; p0_wdata[i] = '0; p1_req_valid[i] = 1'b0; p1_addr[i] = '0;
    end

    // instance 0: 64 bytes, fill A5, latency 1, big endian
    tbl.push_back(rd1(0, 32'h3C, 1'b0, 32'hA5A5A5A5));
    tbl.push_back(wr0(0, 32'h10, 32'hFE010113, 4'b1111, 1'b0));
    tbl.push_back(wr0(0, 32'h10, 32'h00000000, 4'b0101, 1'b0));
    tbl.push_back(both(rd0(0, 32'h10, 1'b0, 32'hFE000100), rd1(0, 32'h10, 1'b0, 32'hFE000100)));
    tbl.push_back(wr0(0, 32'h14, 32'hFFFFFFFF, 4'b0000, 1'b0));
    tbl.push_back(rd0(0, 32'h14, 1'b0, 32'hA5A5A5A5));
    tbl.push_back(rd0(0, 32'h02, 1'b1, 32'h0));
    tbl.push_back(both(rd0(0, 32'h40, 1'b1, 32'h0), rd1(0, 32'h3C, 1'b0, 32'hA5A5A5A5)));
    tbl.push_back(rd0(0, 32'h3C, 1'b0, 32'hA5A5A5A5));
    tbl.push_back(rd1(0, 32'h41, 1'b1, 32'h0));
    tbl.push_back(wr0(0, 32'h3D, 32'h11111111, 4'b1111, 1'b1));
    tbl.push_back(both(rd0(0, 32'h3C, 1'b0, 32'hA5A5A5A5), rd1(0, 32'h3E, 1'b1, 32'h0)));
    // instance 1: 1 KiB, fill 00, latency 2, little endian
    tbl.push_back(both(wr0(1, 32'h20, 32'h12345678, 4'b1111, 1'b0), rd1(1, 32'h20, 1'b0, 32'h0)));
    tbl.push_back(rd1(1, 32'h20, 1'b0, 32'h12345678));
    tbl.push_back(wr0(1, 32'h400, 32'hDEADBEEF, 4'b1111, 1'b1));
    tbl.push_back(rd0(1, 32'h3FC, 1'b0, 32'h0));
    tbl.push_back(both(rd0(1, 32'hFFFFFFFC, 1'b1, 32'h0), rd1(1, 32'h3FC, 1'b0, 32'h0)));
    tbl.push_back(wr0(1, 32'h30, 32'hFE010113, 4'b1111, 1'b0));
    tbl.push_back(wr0(1, 32'h30, 32'h00000000, 4'b1010, 1'b0));
    tbl.push_back(rd0(1, 32'h30, 1'b0, 32'h00010013));
    // instance 2: 1 KiB, latency 4, big endian
    tbl.push_back(wr0(2, 32'h3F8, 32'hCAFEF00D, 4'b0110, 1'b0));
    tbl.push_back(both(rd0(2, 32'h3F8, 1'b0, 32'h00FEF000), rd1(2, 32'h3F8, 1'b0, 32'h00FEF000)));

    // reset and clear sequence timing
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset_init_done", 32'(init_done[i]), 32'd0);
      check("reset_p0_ready", 32'(p0_req_ready[i]), 32'd0);
      check("reset_p1_ready", 32'(p1_req_ready[i]), 32'd0);
      check("reset_p0_valid", 32'(p0_rsp_valid[i]), 32'd0);
      check("reset_p0_rdata", p0_rsp_rdata[i], 32'd0);
      check("reset_p1_err", 32'(p1_rsp_err[i]), 32'd0);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 15) check("init_done_early", 32'(init_done[0]), 32'd0);
    end
    check("init_done_at_16", 32'(init_done[0]), 32'd1);
    check("p0_ready_run", 32'(p0_req_ready[0]), 32'd1);
    wait_init(400);

    for (int t = 0; t < tbl.size(); t++) apply(tbl[t]);
    drain();
    check("be_byte_addr0", 32'(g_dut[0].dut.mem[16]), 32'h000000FE);
    check("le_byte_addr0", 32'(g_dut[1].dut.mem[48]), 32'h00000013);

    // latency sweep: 8 writes, then 8 back-to-back reads per instance
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) apply(wr0(i, 32'(k * 4), sweep_val(i, k), 4'b1111, 1'b0));
      for (int k = 0; k < 8; k++) apply(rd0(i, 32'(k * 4), 1'b0, sweep_val(i, k)));
      drain();
    end

    // reset with three reads in flight on the latency-4 instance
    for (int k = 0; k < 3; k++) apply(rd0(2, 32'(k * 4), 1'b0, sweep_val(2, k)));
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_p0_valid", 32'(p0_rsp_valid[2]), 32'd0);
    check("rst_init_done", 32'(init_done[2]), 32'd0);
    check("rst_p0_ready", 32'(p0_req_ready[2]), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    p0_req_valid[0] = 1'b1; p0_we[0] = 1'b1; p0_wmask[0] = 4'b1111;
    p0_addr[0] = 32'h0; p0_wdata[0] = 32'h55555555;
    check("clear_p0_ready", 32'(p0_req_ready[0]), 32'd0);
    @(posedge clk); #1;
    p0_req_valid[0] = 1'b0; p0_we[0] = 1'b0;
    wait_init(400);
    apply(rd0(0, 32'h00, 1'b0, 32'hA5A5A5A5));
    apply(rd0(1, 32'h20, 1'b0, 32'h00000000));
    apply(rd0(2, 32'h00, 1'b0, 32'h00000000));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
